// File: rtl/data_statistics_ctrl.sv
// Session sequencer for the data_statistics histogram engine: clears the engine, forwards a fixed
// number of samples, drains and closes the session, then sweeps every bin out as (bin, count) words.
module data_statistics_ctrl #(
   parameter int DSIZE      = 10,
   parameter int NBINS      = 16,
   parameter int CSIZE      = 16,
   parameter int LSIZE      = 16,
   parameter int RD_LAT     = 1,
   parameter int START_CYC  = 3,
   parameter int FINISH_GAP = 10,
   parameter int FINISH_CYC = 3,
   localparam int IW        = $clog2(NBINS)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             cmd_start,
   input  logic [LSIZE-1:0] cmd_len,
   input  logic [DSIZE-1:0] in_data,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic             st_start,
   output logic             st_finish,
   output logic [DSIZE-1:0] st_data,
   output logic             st_vld,
   output logic [IW-1:0]    st_index,
   output logic             st_get,
   input  logic [CSIZE-1:0] st_summary,
   output logic [IW-1:0]    out_bin,
   output logic [CSIZE-1:0] out_count,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic             out_last,
   output logic [LSIZE-1:0] ovf_cnt,
   output logic             busy,
   output logic             done
);

   localparam int          CW      = 16;
   localparam logic [31:0] NB      = NBINS;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBINS - 1);

   typedef enum logic [2:0] {
      IDLE, CLEAR, COLLECT, DRAIN, FINISH, READ_REQ, READ_WAIT, READ_OUT
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [LSIZE-1:0] remaining;
   logic [IW-1:0]    idx;
   logic             accept;
   logic             in_range;

   function automatic logic [LSIZE-1:0] sat_inc(input logic [LSIZE-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign in_range = 32'(in_data) < NB;
   assign st_index = idx;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_rdy    = 1'b0;
      st_start  = 1'b0;
      st_finish = 1'b0;
      st_get    = 1'b0;
      out_vld   = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:      if (cmd_start) state_nx = CLEAR;
         CLEAR: begin
            st_start = 1'b1;
            if (cnt == CW'(START_CYC - 1))
               state_nx = (remaining == '0) ? DRAIN : COLLECT;
         end
         COLLECT: begin
            in_rdy = 1'b1;
            accept = in_vld;
            if (accept && remaining <= LSIZE'(1)) state_nx = DRAIN;
         end
         DRAIN:     if (cnt == CW'(FINISH_GAP - 1)) state_nx = FINISH;
         FINISH: begin
            st_finish = 1'b1;
            if (cnt == CW'(FINISH_CYC - 1)) state_nx = READ_REQ;
         end
         READ_REQ: begin
            st_get   = 1'b1;
            state_nx = READ_WAIT;
         end
         READ_WAIT: if (cnt == CW'(RD_LAT - 1)) state_nx = READ_OUT;
         READ_OUT: begin
            out_vld = 1'b1;
            if (out_rdy) begin
               done     = out_last;
               state_nx = out_last ? IDLE : READ_REQ;
            end
         end
         default:   state_nx = IDLE;
      endcase
   end

   // Session datapath: phase counter, sample forwarding, readout capture
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         remaining <= '0;
         idx       <= '0;
         ovf_cnt   <= '0;
         st_data   <= '0;
         st_vld    <= 1'b0;
         out_bin   <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
      end else begin
         cnt    <= (state_nx != state) ? '0 : cnt + 1'b1;
         st_vld <= 1'b0;
         if (state == IDLE && cmd_start) begin
            remaining <= cmd_len;
            ovf_cnt   <= '0;
         end
         if (accept) begin
            if (remaining != '0) remaining <= remaining - 1'b1;
            if (in_range) begin
               st_vld  <= 1'b1;
               st_data <= in_data;
            end else begin
               ovf_cnt <= sat_inc(ovf_cnt);
            end
         end
         if (state == FINISH) idx <= '0;
         if (state == READ_WAIT && cnt == CW'(RD_LAT - 1)) begin
            out_count <= st_summary;
            out_bin   <= idx;
            out_last  <= (idx == LAST_IDX);
         end
         if (state == READ_OUT && out_rdy && idx != LAST_IDX) idx <= idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_data_statistics_ctrl.sv
// Directed bench for data_statistics_ctrl with a behavioural histogram engine attached.
module tb_data_statistics_ctrl;
   localparam int DSIZE = 10, NBINS = 16, CSIZE = 16, LSIZE = 16, IW = 4;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   logic cmd_start = 1'b0;
   logic [LSIZE-1:0] cmd_len = '0;
   logic [DSIZE-1:0] in_data = '0;
   logic in_vld = 1'b0;
   logic in_rdy, st_start, st_finish, st_vld, st_get, out_vld, out_last, busy, done;
   logic [DSIZE-1:0] st_data;
   logic [IW-1:0] st_index, out_bin;
   logic [CSIZE-1:0] st_summary, out_count;
   logic out_rdy = 1'b1;
   logic [LSIZE-1:0] ovf_cnt;

   int nassert = 0, nfail = 0;
   int cyc = 0;
   logic [DSIZE-1:0] samp [0:127];

   always #5 clock = ~clock;

   data_statistics_ctrl #(
      .DSIZE(DSIZE), .NBINS(NBINS), .CSIZE(CSIZE), .LSIZE(LSIZE), .RD_LAT(1),
      .START_CYC(3), .FINISH_GAP(10), .FINISH_CYC(3)
   ) dut (
      .clock(clock), .rst(rst), .cmd_start(cmd_start), .cmd_len(cmd_len),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .st_start(st_start), .st_finish(st_finish), .st_data(st_data), .st_vld(st_vld),
      .st_index(st_index), .st_get(st_get), .st_summary(st_summary),
      .out_bin(out_bin), .out_count(out_count), .out_vld(out_vld), .out_rdy(out_rdy),
      .out_last(out_last), .ovf_cnt(ovf_cnt), .busy(busy), .done(done)
   );

   // behavioural engine: histogram cleared by st_start, one-cycle read latency
   logic [CSIZE-1:0] hist [NBINS];
   always @(posedge clock) begin
      if (st_start) begin
         for (int i = 0; i < NBINS; i++) hist[i] <= '0;
      end else if (st_vld && st_data < NBINS) begin
         hist[st_data[IW-1:0]] <= hist[st_data[IW-1:0]] + 1'b1;
      end
      if (st_get) st_summary <= hist[st_index];
   end

   always @(posedge clock) cyc <= cyc + 1;

   // session monitor, cleared when a session is accepted
   int nvld, nstart, nfin, nrdy, ngets, words, sum, ndone, lastbin, last_vld_cyc, first_fin_cyc;
   logic [CSIZE-1:0] got [NBINS];
   always @(negedge clock) begin
      if (cmd_start && !busy && !rst) begin
         nvld <= 0; nstart <= 0; nfin <= 0; nrdy <= 0; ngets <= 0;
         words <= 0; sum <= 0; ndone <= 0; lastbin <= -1;
         last_vld_cyc <= 0; first_fin_cyc <= 0;
         for (int i = 0; i < NBINS; i++) got[i] <= '0;
      end else begin
         if (st_vld) begin nvld <= nvld + 1; last_vld_cyc <= cyc; end
         if (st_start) nstart <= nstart + 1;
         if (st_finish) begin
            if (nfin == 0) first_fin_cyc <= cyc;
            nfin <= nfin + 1;
         end
         if (in_rdy) nrdy <= nrdy + 1;
         if (st_get) ngets <= ngets + 1;
         if (out_vld && out_rdy) begin
            words <= words + 1;
            got[out_bin] <= out_count;
            sum <= sum + int'(out_count);
            if (out_last) lastbin <= int'(out_bin);
         end
         if (done) ndone <= ndone + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start(input int len);
      cmd_len   = LSIZE'(len);
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
   endtask

   task automatic feed(input int len, input bit inject);
      int k = 0, n = 0;
      bit acc, injected = 0;
      in_vld = 1'b1;
      while (k < len && n < 2000) begin
         in_data = samp[k];
         acc = in_rdy;
         if (inject && k == 3 && !injected) begin
            cmd_len   = LSIZE'(2);
            cmd_start = 1'b1;
            injected  = 1;
         end
         tick();
         cmd_start = 1'b0;
         if (acc) k++;
         n++;
      end
      in_vld = 1'b0;
      chk("feed_timeout", 32'(k), 32'(len));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin tick(); n++; end
      chk("idle_timeout", 32'(busy), 32'(0));
   endtask

   task automatic common(input string t, input int exp_sum);
      chk({t, "_words"}, 32'(words), 32'(16));
      chk({t, "_sum"}, 32'(sum), 32'(exp_sum));
      chk({t, "_lastbin"}, 32'(lastbin), 32'(15));
      chk({t, "_done"}, 32'(ndone), 32'(1));
      chk({t, "_start_cyc"}, 32'(nstart), 32'(3));
      chk({t, "_finish_cyc"}, 32'(nfin), 32'(3));
   endtask

   initial begin
      int others, n, g0;
      bit stable;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_in_rdy", 32'(in_rdy), 32'(0));
      chk("rst_st_start", 32'(st_start), 32'(0));
      chk("rst_out_vld", 32'(out_vld), 32'(0));
      chk("rst_ovf", 32'(ovf_cnt), 32'(0));
      rst = 1'b0;
      tick();

      // 1: 100 samples cycling 0..10
      for (int k = 0; k < 100; k++) samp[k] = DSIZE'(k % 11);
      in_vld = 1'b1;
      start(100);
      feed(100, 0);
      wait_idle();
      chk("t1_nvld", 32'(nvld), 32'(100));
      chk("t1_gap", 32'(first_fin_cyc - last_vld_cyc), 32'(10));
      chk("t1_ovf", 32'(ovf_cnt), 32'(0));
      chk("t1_bin0", 32'(got[0]), 32'(10));
      chk("t1_bin10", 32'(got[10]), 32'(9));
      chk("t1_bin11", 32'(got[11]), 32'(0));
      common("t1", 100);
      chk("t1_done_low", 32'(done), 32'(0));

      // 2: overflow samples dropped
      samp[0] = 3; samp[1] = 20; samp[2] = 3; samp[3] = 15; samp[4] = 40;
      start(5);
      feed(5, 0);
      wait_idle();
      chk("t2_nvld", 32'(nvld), 32'(3));
      chk("t2_ovf", 32'(ovf_cnt), 32'(2));
      chk("t2_bin3", 32'(got[3]), 32'(2));
      chk("t2_bin15", 32'(got[15]), 32'(1));
      others = 0;
      for (int i = 0; i < NBINS; i++) if (i != 3 && i != 15) others += int'(got[i]);
      chk("t2_others", 32'(others), 32'(0));
      common("t2", 3);

      // 3: empty session, in_vld held high throughout
      in_vld = 1'b1;
      in_data = 5;
      start(0);
      wait_idle();
      in_vld = 1'b0;
      chk("t3_nvld", 32'(nvld), 32'(0));
      chk("t3_nrdy", 32'(nrdy), 32'(0));
      common("t3", 0);

      // 4: stall on bin 7
      samp[0] = 7; samp[1] = 7; samp[2] = 7; samp[3] = 1;
      start(4);
      feed(4, 0);
      n = 0;
      while (!(out_vld && out_bin == 7) && n < 500) begin tick(); n++; end
      out_rdy = 1'b0;
      g0 = ngets;
      stable = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!(out_vld && out_bin == 7 && out_count == 3 && !out_last)) stable = 0;
      end
      chk("t4_stable", 32'(stable), 32'(1));
      chk("t4_count", 32'(out_count), 32'(3));
      chk("t4_no_get", 32'(ngets - g0), 32'(0));
      out_rdy = 1'b1;
      wait_idle();
      chk("t4_bin1", 32'(got[1]), 32'(1));
      common("t4", 4);

      // 5: cmd_start during COLLECT ignored
      samp[0] = 1; samp[1] = 2; samp[2] = 20; samp[3] = 3; samp[4] = 4; samp[5] = 5;
      start(6);
      feed(6, 1);
      wait_idle();
      chk("t5_nvld", 32'(nvld), 32'(5));
      chk("t5_ovf", 32'(ovf_cnt), 32'(1));
      chk("t5_bin5", 32'(got[5]), 32'(1));
      common("t5", 5);

      // 6: async reset during READ_OUT, then a clean session
      samp[0] = 0; samp[1] = 30; samp[2] = 0;
      start(3);
      feed(3, 0);
      n = 0;
      while (!out_vld && n < 500) begin tick(); n++; end
      chk("t6_pre_count", 32'(out_count), 32'(2));
      chk("t6_pre_ovf", 32'(ovf_cnt), 32'(1));
      #2 rst = 1'b1;
      #1;
      chk("t6_busy", 32'(busy), 32'(0));
      chk("t6_out_vld", 32'(out_vld), 32'(0));
      chk("t6_out_count", 32'(out_count), 32'(0));
      chk("t6_ovf", 32'(ovf_cnt), 32'(0));
      chk("t6_st_index", 32'(st_index), 32'(0));
      @(posedge clock);
      #1 rst = 1'b0;
      tick();
      samp[0] = 5; samp[1] = 5;
      start(2);
      feed(2, 0);
      wait_idle();
      chk("t6_bin5", 32'(got[5]), 32'(2));
      chk("t6_bin0", 32'(got[0]), 32'(0));
      common("t6", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end
endmodule
